multi_axis_stepper: RTL and testbench

MULTI_AXIS_STEPPER -- requirements
Module: multi_axis_stepper

---
 rtl/multi_axis_stepper.sv | 187 ++++++++++++++++++
 tb/tb_multi_axis_stepper.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_axis_stepper.sv
// Coordinated multi-axis stepper pulse generator.
// The dominant axis steps every period; the others are spread with a Bresenham error accumulator.
module multi_axis_stepper #(
    parameter int unsigned NUM_AXES  = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DIV_W     = 32,
    parameter int unsigned POS_W     = 32,
    parameter int unsigned PULSE_W   = 2,
    parameter int unsigned DIR_SETUP = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [NUM_AXES*CNT_W-1:0] cmd_steps,
    input  logic [NUM_AXES-1:0]       cmd_dir,
    input  logic [DIV_W-1:0]          cmd_period,
    input  logic                      abort,
    input  logic                      pos_clear,
    output logic [NUM_AXES-1:0]       step,
    output logic [NUM_AXES-1:0]       dir,
    output logic [NUM_AXES*POS_W-1:0] pos,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted
);

    localparam int unsigned PER_W      = DIV_W + 1;
    localparam int unsigned SC_W       = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam int unsigned SETUP_LAST = (DIR_SETUP > 0) ? DIR_SETUP - 1 : 0;
    localparam logic [PER_W-1:0] PERIOD_MIN = PER_W'(2 * PULSE_W);
    localparam logic [PER_W-1:0] PULSE_LAST = PER_W'(PULSE_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         steps_lat [NUM_AXES];
    logic [CNT_W-1:0]         err       [NUM_AXES];
    logic [PER_W-1:0]         period_eff;
    logic [PER_W-1:0]         tick;
    logic [SC_W-1:0]          setup_cnt;
    logic [CNT_W-1:0]         remaining;

    logic [CNT_W-1:0]         steps_max_c;
    logic [NUM_AXES-1:0]      ev_step_c;
    logic [CNT_W-1:0]         ev_err_c  [NUM_AXES];
    logic [CNT_W:0]           acc_c;
    logic [NUM_AXES*POS_W-1:0] pos_ev_c;
    logic [PER_W-1:0]         cmd_period_ext;

    assign cmd_period_ext = {1'b0, cmd_period};

    // Dominant axis length
    always_comb begin
        steps_max_c = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            if (steps_lat[i] > steps_max_c) steps_max_c = steps_lat[i];
        end
    end

    // Per-axis step decision and error update for one step event
    always_comb begin
        ev_step_c = '0;
        acc_c     = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            ev_err_c[i] = err[i];
            acc_c = {1'b0, err[i]} + {1'b0, steps_lat[i]};
            if (steps_lat[i] == steps_max_c) begin
                ev_step_c[i] = 1'b1;
            end else if (acc_c >= {1'b0, steps_max_c}) begin
                ev_step_c[i] = 1'b1;
                ev_err_c[i]  = CNT_W'(acc_c - {1'b0, steps_max_c});
            end else begin
                ev_err_c[i]  = CNT_W'(acc_c);
            end
        end
    end

    // Position after the pending step event
    always_comb begin
        pos_ev_c = pos;
        for (int i = 0; i < NUM_AXES; i++) begin
            if (ev_step_c[i]) begin
                pos_ev_c[i*POS_W +: POS_W] = dir[i] ? pos[i*POS_W +: POS_W] + POS_W'(1)
                                                    : pos[i*POS_W +: POS_W] - POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            period_eff <= '0;
            tick       <= '0;
            setup_cnt  <= '0;
            remaining  <= '0;
            for (int i = 0; i < NUM_AXES; i++) begin
                steps_lat[i] <= '0;
                err[i]       <= '0;
            end
            cmd_ready  <= 1'b1;
            step       <= '0;
            dir        <= '0;
            pos        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pos_clear) pos <= '0;
                    if (cmd_valid) begin
                        for (int i = 0; i < NUM_AXES; i++) begin
                            steps_lat[i] <= cmd_steps[i*CNT_W +: CNT_W];
                            err[i]       <= '0;
                        end
                        dir        <= cmd_dir;
                        period_eff <= (cmd_period_ext > PERIOD_MIN) ? cmd_period_ext : PERIOD_MIN;
                        setup_cnt  <= '0;
                        aborted    <= 1'b0;
                        busy       <= 1'b1;
                        cmd_ready  <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (setup_cnt == SC_W'(SETUP_LAST)) begin
                        if (steps_max_c == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // First step event coincides with entering RUN at tick 0
                            state     <= RUN;
                            tick      <= '0;
                            remaining <= steps_max_c - CNT_W'(1);
                            step      <= ev_step_c;
                            pos       <= pos_ev_c;
                            for (int i = 0; i < NUM_AXES; i++) err[i] <= ev_err_c[i];
                        end
                    end else begin
                        setup_cnt <= setup_cnt + SC_W'(1);
                        remaining <= steps_max_c;
                        for (int i = 0; i < NUM_AXES; i++) err[i] <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= DONE;
                        step    <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (tick == period_eff - PER_W'(1)) begin
                        if (remaining == '0) begin
                            state <= DONE;
                            step  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            tick      <= '0;
                            remaining <= remaining - CNT_W'(1);
                            step      <= ev_step_c;
                            pos       <= pos_ev_c;
                            for (int i = 0; i < NUM_AXES; i++) err[i] <= ev_err_c[i];
                        end
                    end else begin
                        tick <= tick + PER_W'(1);
                        if (tick >= PULSE_LAST) step <= '0;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_axis_stepper.sv
// Directed bench for multi_axis_stepper with default parameters (2 axes, PULSE_W=2, DIR_SETUP=4).
module tb_multi_axis_stepper;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic [1:0]  cmd_dir;
    logic [31:0] cmd_period;
    logic        abort;
    logic        pos_clear;
    logic [1:0]  step;
    logic [1:0]  dir;
    logic [63:0] pos;
    logic        busy;
    logic        done;
    logic        aborted;

    int total;
    int bad;

    multi_axis_stepper dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .abort      (abort),
        .pos_clear  (pos_clear),
        .step       (step),
        .dir        (dir),
        .pos        (pos),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] sx, input logic [15:0] sy, input logic [1:0] d,
                         input logic [31:0] p, input logic clr);
        cmd_steps  = {sy, sx};
        cmd_dir    = d;
        cmd_period = p;
        pos_clear  = clr;
        cmd_valid  = 1'b1;
        cyc(1);
        cmd_valid  = 1'b0;
        pos_clear  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_steps = 32'h0001_0001; cmd_dir = 2'b11;
        cmd_period = 32'd10; abort = 1'b0; pos_clear = 1'b0;
        cyc(2);
        total++;
        if ({step, dir, busy, done, aborted, cmd_ready} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {step, dir, busy, done, aborted, cmd_ready}, 8'b0000_0001);
        end
        total++;
        if (pos !== 64'd0) begin bad++; $display("FAIL reset_pos got=%h exp=0", pos); end
        reset = 1'b0; cmd_valid = 1'b0;
        cyc(1);
        total++;
        if ({busy, cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL reset_idle got=%b exp=01", {busy, cmd_ready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp_step;
        issue(16'd4, 16'd2, 2'b11, 32'd10, 1'b0);
        total++;
        if ({dir, busy, cmd_ready} !== 4'b1110) begin
            bad++; $display("FAIL basic_accept got=%b exp=1110", {dir, busy, cmd_ready});
        end
        cyc(4);
        for (int c = 0; c < 40; c++) begin
            exp_step[0] = (c % 10) < 2;
            exp_step[1] = (c == 10) || (c == 11) || (c == 30) || (c == 31);
            total++;
            if ({step, done} !== {exp_step, 1'b0}) begin
                bad++; $display("FAIL basic_run c=%0d got=%b exp=%b", c, {step, done}, {exp_step, 1'b0});
            end
            cyc(1);
        end
        total++;
        if ({done, busy, aborted} !== 3'b100) begin
            bad++; $display("FAIL basic_done got=%b exp=100", {done, busy, aborted});
        end
        total++;
        if (pos !== {32'd2, 32'd4}) begin bad++; $display("FAIL basic_pos got=%h exp=%h", pos, {32'd2, 32'd4}); end
        cyc(1);
        total++;
        if ({done, cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL basic_idle got=%b exp=01", {done, cmd_ready});
        end
    endtask

    task automatic test_zero_steps();
        issue(16'd0, 16'd0, 2'b00, 32'd10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({step, done, busy} !== 4'b0001) begin
                bad++; $display("FAIL zero_setup k=%0d got=%b exp=0001", k, {step, done, busy});
            end
            cyc(1);
        end
        total++;
        if ({done, aborted, step} !== 4'b1000) begin
            bad++; $display("FAIL zero_done got=%b exp=1000", {done, aborted, step});
        end
        total++;
        if (pos !== {32'd2, 32'd4}) begin bad++; $display("FAIL zero_pos got=%h exp=%h", pos, {32'd2, 32'd4}); end
        cyc(1);
    endtask

    task automatic test_min_period();
        logic [1:0] exp_step;
        issue(16'd3, 16'd0, 2'b01, 32'd1, 1'b1);
        total++;
        if (pos !== 64'd0) begin bad++; $display("FAIL minp_clear got=%h exp=0", pos); end
        cyc(4);
        for (int c = 0; c < 12; c++) begin
            exp_step = {1'b0, (c % 4) < 2};
            total++;
            if (step !== exp_step) begin
                bad++; $display("FAIL minp_run c=%0d got=%b exp=%b", c, step, exp_step);
            end
            cyc(1);
        end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL minp_done got=%b exp=1", done); end
        total++;
        if (pos !== {32'd0, 32'd3}) begin bad++; $display("FAIL minp_pos got=%h exp=%h", pos, {32'd0, 32'd3}); end
        cyc(1);
    endtask

    task automatic test_abort();
        logic [1:0] exp_step;
        issue(16'd10, 16'd0, 2'b01, 32'd8, 1'b1);
        cyc(4);
        for (int c = 0; c < 17; c++) begin
            exp_step = {1'b0, (c % 8) < 2};
            total++;
            if (step !== exp_step) begin
                bad++; $display("FAIL abort_run c=%0d got=%b exp=%b", c, step, exp_step);
            end
            cyc(1);
        end
        total++;
        if (step !== 2'b01) begin bad++; $display("FAIL abort_pulse3 got=%b exp=01", step); end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        total++;
        if ({step, done, aborted, busy} !== 5'b00110) begin
            bad++; $display("FAIL abort_done got=%b exp=00110", {step, done, aborted, busy});
        end
        total++;
        if (pos !== {32'd0, 32'd3}) begin bad++; $display("FAIL abort_pos got=%h exp=%h", pos, {32'd0, 32'd3}); end
        cyc(1);
        total++;
        if ({done, aborted, cmd_ready} !== 3'b011) begin
            bad++; $display("FAIL abort_idle got=%b exp=011", {done, aborted, cmd_ready});
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        total++;
        if ({done, busy, cmd_ready, aborted} !== 4'b0011) begin
            bad++; $display("FAIL abort_in_idle got=%b exp=0011", {done, busy, cmd_ready, aborted});
        end
    endtask

    task automatic test_neg_dir();
        logic [1:0] exp_step;
        issue(16'd5, 16'd0, 2'b00, 32'd4, 1'b1);
        total++;
        if (aborted !== 1'b0) begin bad++; $display("FAIL neg_aborted_clear got=%b exp=0", aborted); end
        cyc(4);
        cmd_steps = 32'h0007_0007;
        cmd_dir   = 2'b11;
        for (int c = 0; c < 20; c++) begin
            cmd_valid = (c >= 2) && (c <= 10);
            exp_step = {1'b0, (c % 4) < 2};
            total++;
            if ({step, cmd_ready} !== {exp_step, 1'b0}) begin
                bad++; $display("FAIL neg_run c=%0d got=%b exp=%b", c, {step, cmd_ready}, {exp_step, 1'b0});
            end
            cyc(1);
        end
        cmd_valid = 1'b0;
        total++;
        if ({done, dir} !== 3'b100) begin bad++; $display("FAIL neg_done got=%b exp=100", {done, dir}); end
        total++;
        if (pos !== {32'd0, 32'hFFFF_FFFB}) begin
            bad++; $display("FAIL neg_pos got=%h exp=%h", pos, {32'd0, 32'hFFFF_FFFB});
        end
        cyc(1);
        total++;
        if ({cmd_ready, busy} !== 2'b10) begin bad++; $display("FAIL neg_idle got=%b exp=10", {cmd_ready, busy}); end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen_done;
        issue(16'd6, 16'd3, 2'b11, 32'd6, 1'b0);
        cyc(5);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        total++;
        if ({step, dir, busy, done, aborted, cmd_ready} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL rstmid_outputs got=%b exp=%b", {step, dir, busy, done, aborted, cmd_ready}, 8'b0000_0001);
        end
        total++;
        if (pos !== 64'd0) begin bad++; $display("FAIL rstmid_pos got=%h exp=0", pos); end
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) seen_done++;
            cyc(1);
        end
        total++;
        if (seen_done !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", seen_done); end
        issue(16'd2, 16'd1, 2'b10, 32'd4, 1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b exp=1", busy); end
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            cyc(1);
            n++;
        end
        total++;
        if (n !== 12) begin bad++; $display("FAIL rstmid_latency got=%0d exp=12", n); end
        total++;
        if (pos !== {32'd1, 32'hFFFF_FFFE}) begin
            bad++; $display("FAIL rstmid_pos2 got=%h exp=%h", pos, {32'd1, 32'hFFFF_FFFE});
        end
        cyc(1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_zero_steps();
        test_min_period();
        test_abort();
        test_neg_dir();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
